inst_fetch: RTL and testbench

//  Instruction-fetch front end of the render processor. Walks a program counter through
//  the instruction BRAM and presents {pc_out, instruction, valid_out} to the instruction

---
 rtl/inst_fetch_if.sv | 28 ++
 rtl/inst_fetch.sv | 264 ++++++++++++++++++++++++++
 tb/tb_inst_fetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: controller handshake, BRAM read port and the word
// stream handed to the instruction parser.
interface inst_fetch_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] start_pc;
   logic                  stall;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  halt;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_rdata;
   logic                  valid_out;
   logic [31:0]           instruction;
   logic [ADDR_WIDTH-1:0] pc_out;
   logic                  busy;

   modport master (
      output start, start_pc, stall, redirect, redirect_pc, halt, mem_rdata,
      input  mem_addr, valid_out, instruction, pc_out, busy
   );

   modport slave (
      input  start, start_pc, stall, redirect, redirect_pc, halt, mem_rdata,
      output mem_addr, valid_out, instruction, pc_out, busy
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch front end: issues BRAM reads, tags them with an epoch so
// redirects can discard stale returns, and buffers returns behind a stallable output.
module inst_fetch #(
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int PROG_LEN    = 0
) (
   input logic         clk,
   input logic         rst,
   inst_fetch_if.slave bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int INF_W = $clog2(MEM_LATENCY + 2);
   localparam int OCC_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic                  epoch_r;
   logic                  epoch_nxt_s;

   // address stage: the read presented on mem_addr this cycle
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic                  av_r;
   logic                  ae_r;

   // in-flight tracking, stage MEM_LATENCY-1 lines up with mem_rdata
   logic                  sv_r  [MEM_LATENCY];
   logic                  se_r  [MEM_LATENCY];
   logic [ADDR_WIDTH-1:0] spc_r [MEM_LATENCY];

   logic [ADDR_WIDTH-1:0] fifo_pc_r   [FIFO_DEPTH];
   logic [31:0]           fifo_data_r [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [CNT_W-1:0]      fifo_count_r;

   logic                  valid_out_r;
   logic [31:0]           instr_r;
   logic [ADDR_WIDTH-1:0] pc_out_r;
   logic                  busy_r;

   logic                  redirect_act_s;
   logic                  start_act_s;
   logic                  issue_s;
   logic [ADDR_WIDTH-1:0] issue_pc_s;
   logic [INF_W-1:0]      inflight_s;
   logic [OCC_W-1:0]      occ_s;
   logic                  ret_s;
   logic                  can_load_s;
   logic                  fifo_empty_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  bypass_s;

   function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] pc);
      logic [ADDR_WIDTH-1:0] nxt;
      nxt = pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if ((PROG_LEN != 0) && (nxt == ADDR_WIDTH'(PROG_LEN))) begin
         return {ADDR_WIDTH{1'b0}};
      end else begin
         return nxt;
      end
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + {{(PTR_W-1){1'b0}}, 1'b1};
      end
   endfunction

   assign redirect_act_s = bus.redirect && (state_r != IDLE);
   assign start_act_s    = bus.start && (state_r == IDLE);
   assign epoch_nxt_s    = epoch_r ^ redirect_act_s;
   assign fifo_empty_s   = (fifo_count_r == {CNT_W{1'b0}});
   assign can_load_s     = !valid_out_r || !bus.stall;

   // count of reads issued but not yet returned, stale ones included
   always_comb begin
      inflight_s = INF_W'(av_r);
      for (int i = 0; i < MEM_LATENCY; i++) begin
         inflight_s = inflight_s + INF_W'(sv_r[i]);
      end
      occ_s = OCC_W'(fifo_count_r) + OCC_W'(inflight_s);
   end

   // issue selection: redirect and start restart the stream, RUN fills to capacity
   always_comb begin
      issue_s    = 1'b0;
      issue_pc_s = pc_r;
      if (redirect_act_s) begin
         issue_s    = 1'b1;
         issue_pc_s = bus.redirect_pc;
      end else if (start_act_s) begin
         issue_s    = 1'b1;
         issue_pc_s = bus.start_pc;
      end else if ((state_r == RUN) && !bus.halt && (occ_s < OCC_W'(FIFO_DEPTH))) begin
         issue_s    = 1'b1;
         issue_pc_s = pc_r;
      end else begin
         issue_s    = 1'b0;
      end
   end

   // return routing: FIFO head has priority, an empty FIFO lets the return fall through
   always_comb begin
      ret_s    = sv_r[MEM_LATENCY-1] && (se_r[MEM_LATENCY-1] == epoch_r) && !redirect_act_s;
      push_s   = 1'b0;
      pop_s    = 1'b0;
      bypass_s = 1'b0;
      if (redirect_act_s) begin
         push_s = 1'b0;
      end else if (can_load_s) begin
         if (!fifo_empty_s) begin
            pop_s  = 1'b1;
            push_s = ret_s;
         end else begin
            bypass_s = ret_s;
         end
      end else begin
         push_s = ret_s;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt_s = state_r;
      if (redirect_act_s) begin
         state_nxt_s = RUN;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            RUN: begin
               if (bus.halt) begin
                  state_nxt_s = DRAIN;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            DRAIN: begin
               if ((inflight_s == {INF_W{1'b0}}) && fifo_empty_s && can_load_s) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = DRAIN;
               end
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // state, pc, epoch and busy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         pc_r    <= {ADDR_WIDTH{1'b0}};
         epoch_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         epoch_r <= epoch_nxt_s;
         busy_r  <= (state_nxt_s != IDLE);
         if (issue_s) begin
            pc_r <= pc_inc(issue_pc_s);
         end
      end
   end

   // address stage and in-flight shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr_r <= {ADDR_WIDTH{1'b0}};
         av_r       <= 1'b0;
         ae_r       <= 1'b0;
         for (int i = 0; i < MEM_LATENCY; i++) begin
            sv_r[i]  <= 1'b0;
            se_r[i]  <= 1'b0;
            spc_r[i] <= {ADDR_WIDTH{1'b0}};
         end
      end else begin
         av_r <= issue_s;
         ae_r <= epoch_nxt_s;
         if (issue_s) begin
            mem_addr_r <= issue_pc_s;
         end
         sv_r[0]  <= av_r;
         se_r[0]  <= ae_r;
         spc_r[0] <= mem_addr_r;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            sv_r[i]  <= sv_r[i-1];
            se_r[i]  <= se_r[i-1];
            spc_r[i] <= spc_r[i-1];
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst || redirect_act_s) begin
         rd_ptr_r     <= {PTR_W{1'b0}};
         wr_ptr_r     <= {PTR_W{1'b0}};
         fifo_count_r <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         fifo_count_r <= fifo_count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_pc_r[wr_ptr_r]   <= spc_r[MEM_LATENCY-1];
         fifo_data_r[wr_ptr_r] <= bus.mem_rdata;
      end
   end

   // output register: holds bit-stable while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out_r <= 1'b0;
         instr_r     <= 32'd0;
         pc_out_r    <= {ADDR_WIDTH{1'b0}};
      end else if (redirect_act_s) begin
         valid_out_r <= 1'b0;
      end else if (pop_s) begin
         valid_out_r <= 1'b1;
         instr_r     <= fifo_data_r[rd_ptr_r];
         pc_out_r    <= fifo_pc_r[rd_ptr_r];
      end else if (bypass_s) begin
         valid_out_r <= 1'b1;
         instr_r     <= bus.mem_rdata;
         pc_out_r    <= spc_r[MEM_LATENCY-1];
      end else if (can_load_s) begin
         valid_out_r <= 1'b0;
      end
   end

   assign bus.mem_addr    = mem_addr_r;
   assign bus.valid_out   = valid_out_r;
   assign bus.instruction = instr_r;
   assign bus.pc_out      = pc_out_r;
   assign bus.busy        = busy_r;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle-by-cycle vector table plus a wrap-around
// sequence on a second instance built with an eight-word program.
module tb_inst_fetch;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_fetch_if #(.ADDR_WIDTH(AW)) bif ();
   inst_fetch_if #(.ADDR_WIDTH(AW)) bif8 ();

   inst_fetch #(.ADDR_WIDTH(AW), .MEM_LATENCY(2), .FIFO_DEPTH(4), .PROG_LEN(0))
      dut (.clk(clk), .rst(rst), .bus(bif));
   inst_fetch #(.ADDR_WIDTH(AW), .MEM_LATENCY(2), .FIFO_DEPTH(4), .PROG_LEN(8))
      dut8 (.clk(clk), .rst(rst), .bus(bif8));

   // two-cycle BRAM models holding word i = i*3
   logic [AW-1:0] a1, a1_8;
   always @(posedge clk) begin
      a1              <= bif.mem_addr;
      bif.mem_rdata   <= 32'(a1) * 32'd3;
      a1_8            <= bif8.mem_addr;
      bif8.mem_rdata  <= 32'(a1_8) * 32'd3;
   end

   typedef struct {
      logic          rst, start, stall, halt, redir;
      logic [AW-1:0] pin;
      logic          ev;
      logic [AW-1:0] epc;
      logic          eb;
      logic          cd;
      logic          ca;
      logic [AW-1:0] ea;
   } vec_t;

   vec_t vq[$];
   int   errors = 0;
   int   checks = 0;
   int   max_fifo = 0;

   always @(negedge clk) begin
      if (int'(dut.fifo_count_r) > max_fifo) max_fifo = int'(dut.fifo_count_r);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input bit r, s, st, h, rd, input int pin,
                               input bit ev, input int epc, input bit eb,
                               input bit cd, input bit ca, input int ea);
      vec_t v;
      v.rst = r; v.start = s; v.stall = st; v.halt = h; v.redir = rd;
      v.pin = AW'(pin); v.ev = ev; v.epc = AW'(epc); v.eb = eb;
      v.cd = cd; v.ca = ca; v.ea = AW'(ea);
      vq.push_back(v);
   endfunction

   initial begin
      logic [AW-1:0] addr8_exp [3];
      logic [AW-1:0] pc8_exp [5];
      addr8_exp = '{16'd6, 16'd7, 16'd0};
      pc8_exp   = '{16'd6, 16'd7, 16'd0, 16'd1, 16'd2};

      // A: start at 0, stall at pc 2, redirect to 0x10 with a stall pending
      add(0,1,0,0,0,0,     0,0,0, 0,0,0);
      for (int c = 1; c <= 3; c++) add(0,0,0,0,0,0, 0,0,1, 0,1,c-1);
      for (int c = 4; c <= 5; c++) add(0,0,0,0,0,0, 1,c-4,1, 0,0,0);
      for (int c = 6; c <= 10; c++) add(0,0,1,0,0,0, 1,2,1, 0,0,0);
      add(0,0,0,0,0,0,     1,2,1, 0,0,0);
      for (int c = 12; c <= 14; c++) add(0,0,0,0,0,0, 1,c-9,1, 0,0,0);
      add(0,0,1,0,1,16'h10, 1,6,1, 0,0,0);
      add(0,0,0,0,0,0,     0,0,1, 0,1,16'h10);
      add(0,0,0,0,0,0,     0,0,1, 0,1,16'h11);
      add(0,0,0,0,0,0,     0,0,1, 0,0,0);
      for (int c = 19; c <= 22; c++) add(0,0,0,0,0,0, 1,c-3,1, 0,0,0);
      add(1,0,0,0,0,0,     1,16'h14,1, 0,0,0);
      // B: reset state, restart at 0, halt at pc 9 and drain to idle
      add(0,1,0,0,0,0,     0,0,0, 1,1,0);
      for (int b = 1; b <= 3; b++) add(0,0,0,0,0,0, 0,0,1, 0,0,0);
      for (int b = 4; b <= 12; b++) add(0,0,0,0,0,0, 1,b-4,1, 0,0,0);
      add(0,0,0,1,0,0,     1,9,1, 0,0,0);
      for (int b = 14; b <= 16; b++) add(0,0,0,0,0,0, 1,b-4,1, 0,0,0);
      add(0,0,0,0,0,0,     0,0,0, 0,0,0);
      // C: restart from idle, reset while stalled, start again at pc 4
      add(0,1,0,0,0,0,     0,0,0, 0,0,0);
      for (int c = 1; c <= 3; c++) add(0,0,0,0,0,0, 0,0,1, 0,0,0);
      for (int c = 4; c <= 5; c++) add(0,0,0,0,0,0, 1,c-4,1, 0,0,0);
      add(0,0,1,0,0,0,     1,2,1, 0,0,0);
      add(1,0,1,0,0,0,     1,2,1, 0,0,0);
      add(0,1,0,0,0,4,     0,0,0, 1,1,0);
      add(0,0,0,0,0,0,     0,0,1, 0,1,4);
      for (int c = 10; c <= 11; c++) add(0,0,0,0,0,0, 0,0,1, 0,0,0);
      for (int c = 12; c <= 13; c++) add(0,0,0,0,0,0, 1,c-8,1, 0,0,0);

      rst = 1'b1;
      bif.start = 1'b0; bif.start_pc = '0; bif.stall = 1'b0; bif.redirect = 1'b0;
      bif.redirect_pc = '0; bif.halt = 1'b0;
      bif8.start = 1'b0; bif8.start_pc = '0; bif8.stall = 1'b0; bif8.redirect = 1'b0;
      bif8.redirect_pc = '0; bif8.halt = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset valid_out", 32'(bif.valid_out), 32'd0);
      check("reset instruction", bif.instruction, 32'd0);
      check("reset pc_out", 32'(bif.pc_out), 32'd0);
      check("reset mem_addr", 32'(bif.mem_addr), 32'd0);
      check("reset busy", 32'(bif.busy), 32'd0);

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk); #1;
         rst             = vq[i].rst;
         bif.start       = vq[i].start;
         bif.start_pc    = vq[i].pin;
         bif.redirect_pc = vq[i].pin;
         bif.stall       = vq[i].stall;
         bif.halt        = vq[i].halt;
         bif.redirect    = vq[i].redir;
         @(negedge clk);
         check($sformatf("row%0d valid_out", i), 32'(bif.valid_out), 32'(vq[i].ev));
         check($sformatf("row%0d busy", i), 32'(bif.busy), 32'(vq[i].eb));
         if (vq[i].ev || vq[i].cd) begin
            check($sformatf("row%0d pc_out", i), 32'(bif.pc_out), 32'(vq[i].epc));
            check($sformatf("row%0d instruction", i), bif.instruction,
                  vq[i].ev ? 32'(vq[i].epc) * 32'd3 : 32'd0);
         end
         if (vq[i].ca) begin
            check($sformatf("row%0d mem_addr", i), 32'(bif.mem_addr), 32'(vq[i].ea));
         end
      end
      @(posedge clk); #1;
      bif.start = 1'b0;
      check("fifo peak occupancy", 32'(max_fifo), 32'd4);

      // wrap-around at an eight-word program, starting at pc 6
      bif8.start = 1'b1; bif8.start_pc = 16'd6;
      @(posedge clk); #1;
      bif8.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("wrap mem_addr%0d", k), 32'(bif8.mem_addr), 32'(addr8_exp[k]));
         @(posedge clk);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("wrap valid%0d", k), 32'(bif8.valid_out), 32'd1);
         check($sformatf("wrap pc_out%0d", k), 32'(bif8.pc_out), 32'(pc8_exp[k]));
         check($sformatf("wrap instruction%0d", k), bif8.instruction, 32'(pc8_exp[k]) * 32'd3);
         @(posedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
